// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge filter.
// The sat8 function is used by both the datapath and its checking model.
package sobel_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned GRAD_W     = 11;
    localparam int unsigned MAG_W      = 12;
    localparam int unsigned DEF_WIDTH  = 640;
    localparam int unsigned DEF_HEIGHT = 480;
    localparam int unsigned COL_W      = $clog2(DEF_WIDTH);
    localparam int unsigned ROW_W      = $clog2(DEF_HEIGHT);
    localparam int unsigned LATENCY    = 3;

    function automatic logic [DATA_W-1:0] sat8(input logic [MAG_W-1:0] mag);
        return (mag > MAG_W'(255)) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: simple dual-port RAM, registered read, read-before-write.
// Output holds its value between read enables so gaps in the stream do not disturb the window.
module sobel_line_buffer #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [WIDTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: |Gx|+|Gy|, saturated, optional threshold.
// Output stream is the input frame delayed by one line plus one pixel, three register stages.
module sobel_stream_filter #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned THRESH = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic [DATA_W-1:0] pix_out,
    output logic              out_valid,
    output logic              out_sof
);

    import sobel_pkg::*;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    function automatic logic signed [GRAD_W-1:0] ext(input logic [DATA_W-1:0] v);
        return signed'(GRAD_W'(v));
    endfunction

    // Position counters
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    always_comb begin
        cur_col = pix_sof ? '0 : col_q;
        cur_row = pix_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (pix_valid) begin
            if (cur_col == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row == RW'(HEIGHT - 1)) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // S0: line buffers and window shift registers
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [DATA_W-1:0] live_q [3];
    logic [DATA_W-1:0] mid_q [2];
    logic [DATA_W-1:0] top_q [2];
    logic              s0_valid_q, s0_sof_q, s0_border_q;
    logic [CW-1:0]     s0_col_q;

    sobel_line_buffer #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (CW)
    ) u_lb0 (
        .clk_i     (clock),
        .wr_en_i   (pix_valid),
        .wr_addr_i (cur_col),
        .wr_data_i (pix_in),
        .rd_en_i   (pix_valid),
        .rd_addr_i (cur_col),
        .rd_data_o (lb0_rd)
    );

    // lb1 takes lb0's old line one cycle later, once that data has been read out
    sobel_line_buffer #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W),
        .ADDR_W (CW)
    ) u_lb1 (
        .clk_i     (clock),
        .wr_en_i   (s0_valid_q),
        .wr_addr_i (s0_col_q),
        .wr_data_i (lb0_rd),
        .rd_en_i   (pix_valid),
        .rd_addr_i (cur_col),
        .rd_data_o (lb1_rd)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col_q       <= '0;
            row_q       <= '0;
            s0_valid_q  <= 1'b0;
            s0_sof_q    <= 1'b0;
            s0_border_q <= 1'b1;
            s0_col_q    <= '0;
            for (int i = 0; i < 3; i++) live_q[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                mid_q[i] <= '0;
                top_q[i] <= '0;
            end
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s0_valid_q <= pix_valid;
            s0_sof_q   <= pix_valid & pix_sof;
            if (pix_valid) begin
                live_q[2]   <= pix_in;
                live_q[1]   <= live_q[2];
                live_q[0]   <= live_q[1];
                mid_q[1]    <= lb0_rd;
                mid_q[0]    <= mid_q[1];
                top_q[1]    <= lb1_rd;
                top_q[0]    <= top_q[1];
                s0_col_q    <= cur_col;
                s0_border_q <= (cur_row < RW'(2)) || (cur_col < CW'(2));
            end
        end
    end

    // S1: gradients; the RAM read registers double as the newest window column
    logic signed [GRAD_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic                     s1_valid_q, s1_sof_q, s1_border_q;

    always_comb begin
        gx_d = (ext(lb1_rd) + (ext(lb0_rd) <<< 1) + ext(live_q[2]))
             - (ext(top_q[0]) + (ext(mid_q[0]) <<< 1) + ext(live_q[0]));
        gy_d = (ext(live_q[0]) + (ext(live_q[1]) <<< 1) + ext(live_q[2]))
             - (ext(top_q[0]) + (ext(top_q[1]) <<< 1) + ext(lb1_rd));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gx_q        <= '0;
            gy_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_border_q <= 1'b1;
        end else begin
            s1_valid_q  <= s0_valid_q;
            s1_sof_q    <= s0_sof_q;
            s1_border_q <= s0_border_q;
            if (s0_valid_q) begin
                gx_q <= gx_d;
                gy_q <= gy_d;
            end
        end
    end

    // S2: magnitude, saturation, threshold, border mask
    logic [GRAD_W-1:0] ax, ay;
    logic [MAG_W-1:0]  mag;
    logic [DATA_W-1:0] sat, res;
    logic [DATA_W-1:0] pix_out_q;
    logic              out_valid_q, out_sof_q;

    always_comb begin
        ax  = gx_q[GRAD_W-1] ? GRAD_W'(-gx_q) : GRAD_W'(gx_q);
        ay  = gy_q[GRAD_W-1] ? GRAD_W'(-gy_q) : GRAD_W'(gy_q);
        mag = {1'b0, ax} + {1'b0, ay};
        sat = DATA_W'(sat8(mag));
        res = sat;
        if (THRESH != 0) begin
            res = (32'(sat) >= THRESH) ? '1 : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_out_q   <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            out_sof_q   <= s1_sof_q;
            if (s1_valid_q) begin
                pix_out_q <= s1_border_q ? '0 : res;
            end
        end
    end

    assign pix_out   = pix_out_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Bench for sobel_stream_filter: an image-based reference model feeds a scoreboard,
// with a plain-magnitude instance and a thresholded instance driven in parallel.
module tb_sobel_stream_filter;

    import sobel_pkg::*;

    localparam int W   = 8;
    localparam int H   = 6;
    localparam int LAT = 3;
    localparam int THR = 128;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic [7:0] out0, out1;
    logic       ov0, ov1, os0, os1;

    sobel_stream_filter #(
        .WIDTH  (W),
        .HEIGHT (H),
        .DATA_W (8),
        .THRESH (0)
    ) dut0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_out   (out0),
        .out_valid (ov0),
        .out_sof   (os0)
    );

    sobel_stream_filter #(
        .WIDTH  (W),
        .HEIGHT (H),
        .DATA_W (8),
        .THRESH (THR)
    ) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_out   (out1),
        .out_valid (ov1),
        .out_sof   (os1)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic       sof;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   img [H][W];
    int   mr = 0, mc = 0;
    int   n_tests = 0, n_fail = 0;
    int   n_out = 0, n_sof = 0, n_nz0 = 0, n_nz1 = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int model_pix(input int r, input int c);
        int gx, gy;
        if (r < 2 || c < 2) return 0;
        gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
        return int'(sat8(12'(iabs(gx) + iabs(gy))));
    endfunction

    task automatic drive_beat(input logic [7:0] px, input logic sof);
        exp_t e;
        int   v;
        @(posedge clock);
        #1;
        pix_in = px;
        pix_valid = 1'b1;
        pix_sof = sof;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = int'(px);
        v = model_pix(mr, mc);
        e.d0 = 8'(v);
        e.d1 = (v >= THR) ? 8'hFF : 8'h00;
        e.sof = sof;
        e.cyc = cyc + LAT;
        sb.push_back(e);
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            pix_valid = 1'b0;
            pix_sof = 1'b0;
        end
    endtask

    // Scoreboard: every output beat must match the head entry, on the expected cycle
    always @(negedge clock) begin
        if (reset_n) begin
            if (ov0) begin
                n_out++;
                if (os0) n_sof++;
                if (out0 != 0) n_nz0++;
                if (out1 != 0) n_nz1++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output cyc=%0d pix=%0d sof=%b required: none", cyc,
                             out0, os0);
                end else begin
                    got_e = sb.pop_front();
                    if (out0 !== got_e.d0 || ov1 !== 1'b1 || out1 !== got_e.d1 ||
                        os0 !== got_e.sof || os1 !== got_e.sof || cyc !== got_e.cyc) begin
                        n_fail++;
                        $display("FAIL output_beat got pix=%0d thr=%0d v1=%b sof=%b/%b cyc=%0d required pix=%0d thr=%0d sof=%b cyc=%0d",
                                 out0, out1, ov1, os0, os1, cyc, got_e.d0, got_e.d1, got_e.sof,
                                 got_e.cyc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_output cyc=%0d got out_valid=0 required 1 (due %0d)", cyc,
                         sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic test_reset();
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (ov0 !== 1'b0 || os0 !== 1'b0 || out0 !== 8'd0 || ov1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async got v=%b sof=%b pix=%0d v1=%b required 0", ov0, os0,
                     out0, ov1);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (ov0 !== 1'b0 || os0 !== 1'b0 || out0 !== 8'd0 || out1 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_hold got v=%b sof=%b pix=%0d/%0d required 0", ov0, os0, out0,
                     out1);
        end
        #1;
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic run_frame_checks(input string name, input int out_before, input int sof_before,
                                    input int nz0_before, input int nz1_before, input int exp_out,
                                    input int exp_sof, input int exp_nz0, input int exp_nz1);
        n_tests++;
        if (n_out - out_before !== exp_out || n_sof - sof_before !== exp_sof) begin
            n_fail++;
            $display("FAIL %s_counts got outputs=%0d sofs=%0d required %0d/%0d", name,
                     n_out - out_before, n_sof - sof_before, exp_out, exp_sof);
        end
        n_tests++;
        if (n_nz0 - nz0_before !== exp_nz0 || n_nz1 - nz1_before !== exp_nz1) begin
            n_fail++;
            $display("FAIL %s_nonzero got %0d/%0d required %0d/%0d", name, n_nz0 - nz0_before,
                     n_nz1 - nz1_before, exp_nz0, exp_nz1);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got %0d pending required 0", name, sb.size());
        end
    endtask

    task automatic test_flat(input string name);
        int o = n_out, s = n_sof, z0 = n_nz0, z1 = n_nz1;
        for (int i = 0; i < W * H; i++) drive_beat(8'd50, i == 0);
        idle(6);
        run_frame_checks(name, o, s, z0, z1, W * H, 1, 0, 0);
    endtask

    task automatic test_vstep(input string name, input logic [7:0] amp);
        int o = n_out, s = n_sof, z0 = n_nz0, z1 = n_nz1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) drive_beat((c >= 4) ? amp : 8'd0, r == 0 && c == 0);
        idle(6);
        run_frame_checks(name, o, s, z0, z1, W * H, 1, 8, 8);
    endtask

    task automatic test_hstep_gaps();
        int o = n_out, s = n_sof, z0 = n_nz0, z1 = n_nz1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                drive_beat((r >= 3) ? 8'd30 : 8'd0, r == 0 && c == 0);
                idle(1);
            end
        idle(6);
        run_frame_checks("hstep", o, s, z0, z1, W * H, 1, 12, 0);
    endtask

    task automatic test_mid_sof();
        int o = n_out, s = n_sof;
        for (int i = 0; i < 3 * W + 5; i++) drive_beat(8'($urandom_range(0, 255)), i == 0);
        for (int i = 0; i < W * H; i++) drive_beat(8'($urandom_range(0, 255)), i == 0);
        idle(6);
        n_tests++;
        if (n_out - o !== 3 * W + 5 + W * H || n_sof - s !== 2) begin
            n_fail++;
            $display("FAIL mid_sof_counts got outputs=%0d sofs=%0d required %0d/2", n_out - o,
                     n_sof - s, 3 * W + 5 + W * H);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL mid_sof_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        logic pre;
        int   o;
        for (int i = 0; i < 20; i++) drive_beat(8'($urandom_range(0, 255)), i == 0);
        @(negedge clock);
        pre = ov0;
        #2;
        reset_n = 1'b0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        #1;
        n_tests++;
        if (pre !== 1'b1 || ov0 !== 1'b0 || ov1 !== 1'b0 || os0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_drop got before=%b after=%b/%b required 1 then 0", pre,
                     ov0, ov1);
        end
        sb.delete();
        mr = 0;
        mc = 0;
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        o = n_out;
        idle(6);
        n_tests++;
        if (n_out !== o) begin
            n_fail++;
            $display("FAIL reset_mid_stale got %0d outputs required 0", n_out - o);
        end
        test_flat("post_reset_flat");
    endtask

    initial begin
        test_reset();
        test_flat("flat");
        test_vstep("vstep40", 8'd40);
        test_vstep("vstep100", 8'd100);
        test_hstep_gaps();
        test_mid_sof();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
